// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one registered-output ALU between NUM_REQ requesters.
// One operation in flight at a time: accept, execute, capture, respond.
module alu_sched #(
  parameter int OPCODE_WIDTH = 2,
  parameter int DATA_WIDTH   = 3,
  parameter int NUM_REQ      = 4
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*(OPCODE_WIDTH+1)-1:0] req_opcode,
  input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0]   req_op1,
  input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0]   req_op2,
  output logic [OPCODE_WIDTH:0]               alu_opcode,
  output logic [DATA_WIDTH:0]                 alu_op1,
  output logic [DATA_WIDTH:0]                 alu_op2,
  input  logic [DATA_WIDTH:0]                 alu_result,
  input  logic                                alu_carry,
  input  logic                                alu_zero,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  input  logic [NUM_REQ-1:0]                  rsp_ready,
  output logic [DATA_WIDTH:0]                 rsp_result,
  output logic                                rsp_carry,
  output logic                                rsp_zero,
  output logic                                busy
);

  localparam int OW = OPCODE_WIDTH + 1;
  localparam int DW = DATA_WIDTH + 1;
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t               state_r;
  logic [PW-1:0]        last_grant_r;
  logic [PW-1:0]        grant_id_r;
  logic [OW-1:0]        alu_opcode_r;
  logic [DW-1:0]        alu_op1_r;
  logic [DW-1:0]        alu_op2_r;
  logic [NUM_REQ-1:0]   rsp_valid_r;
  logic [DW-1:0]        rsp_result_r;
  logic                 rsp_carry_r;
  logic                 rsp_zero_r;
  logic                 busy_r;

  logic [PW-1:0]        winner_s;
  logic                 found_s;
  logic [PW-1:0]        idx_s;
  logic [NUM_REQ-1:0]   req_ready_s;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    idx_s    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s = PW'((int'(last_grant_r) + k) % NUM_REQ);
      if (!found_s && req_valid[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Grant is combinational in IDLE so a lone requester is accepted the same cycle.
  always_comb begin
    req_ready_s = '0;
    if (rstn && (state_r == IDLE) && found_s) begin
      req_ready_s[winner_s] = 1'b1;
    end else begin
      req_ready_s = '0;
    end
  end

  // Scheduler FSM with all datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      last_grant_r <= PW'(NUM_REQ - 1);
      grant_id_r   <= '0;
      alu_opcode_r <= '0;
      alu_op1_r    <= '0;
      alu_op2_r    <= '0;
      rsp_valid_r  <= '0;
      rsp_result_r <= '0;
      rsp_carry_r  <= 1'b0;
      rsp_zero_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            alu_opcode_r <= req_opcode[int'(winner_s)*OW +: OW];
            alu_op1_r    <= req_op1[int'(winner_s)*DW +: DW];
            alu_op2_r    <= req_op2[int'(winner_s)*DW +: DW];
            last_grant_r <= winner_s;
            grant_id_r   <= winner_s;
            busy_r       <= 1'b1;
            state_r      <= EXEC;
          end else begin
            state_r      <= IDLE;
          end
        end
        EXEC: state_r <= CAPT;
        CAPT: begin
          rsp_result_r <= alu_result;
          rsp_carry_r  <= alu_carry;
          rsp_zero_r   <= alu_zero;
          rsp_valid_r  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_r;
          state_r      <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant_id_r]) begin
            rsp_valid_r <= '0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= RESP;
          end
        end
        default: begin
          rsp_valid_r <= '0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_s;
  assign alu_opcode = alu_opcode_r;
  assign alu_op1    = alu_op1_r;
  assign alu_op2    = alu_op2_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_carry  = rsp_carry_r;
  assign rsp_zero   = rsp_zero_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: behavioural ALU on the alu_* side, transaction-level
// round-robin/response model, directed scenarios plus randomized traffic.
module tb_alu_sched;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req_valid = 4'd0;
  logic [3:0]  req_ready;
  logic [11:0] req_opcode = 12'd0;
  logic [15:0] req_op1 = 16'd0;
  logic [15:0] req_op2 = 16'd0;
  logic [2:0]  alu_opcode;
  logic [3:0]  alu_op1, alu_op2;
  logic [3:0]  alu_result;
  logic        alu_carry, alu_zero;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready = 4'd0;
  logic [3:0]  rsp_result;
  logic        rsp_carry, rsp_zero;
  logic        busy;

  int nchk = 0;
  int nerr = 0;
  int lg = 3;
  logic [2:0] opc [4];
  logic [3:0] opa [4];
  logic [3:0] opb [4];

  alu_sched dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU opcode map: ADD, SUB(borrow), INCR, DECR, AND, OR, XOR, NOT
  function automatic logic [5:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] w;
    case (op)
      3'd0: w = {1'b0, a} + {1'b0, b};
      3'd1: w = {1'b0, a} - {1'b0, b};
      3'd2: w = {1'b0, a} + 5'd1;
      3'd3: w = {1'b0, a} - 5'd1;
      3'd4: w = {1'b0, a & b};
      3'd5: w = {1'b0, a | b};
      3'd6: w = {1'b0, a ^ b};
      default: w = {1'b0, ~a};
    endcase
    return {w[4], (w[3:0] == 4'd0), w[3:0]};
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) {alu_carry, alu_zero, alu_result} <= 6'd0;
    else       {alu_carry, alu_zero, alu_result} <= alu_fn(alu_opcode, alu_op1, alu_op2);
  end

  task automatic set_op(input int i, input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
    opc[i] = o; opa[i] = a; opb[i] = b;
    req_opcode[i*3 +: 3] = o;
    req_op1[i*4 +: 4] = a;
    req_op2[i*4 +: 4] = b;
  endtask

  // One full transaction; called just after a rising edge with the DUT idle.
  task automatic do_op(input logic [3:0] mask, input bit keep, input int bp,
                       output int w, output logic [3:0] res, output logic c, output logic z);
    logic [3:0] oh;
    w = -1;
    for (int k = 1; k <= 4; k++) begin
      if (w < 0 && mask[(lg + k) % 4]) w = (lg + k) % 4;
    end
    lg = w;
    oh = 4'd0; oh[w] = 1'b1;
    req_valid = mask;
    @(negedge clk);
    nchk++;
    if (req_ready !== oh) begin nerr++; $display("FAIL grant: req_ready=%b want %b", req_ready, oh); end
    @(posedge clk); #1;
    if (!keep) req_valid = 4'd0;
    @(negedge clk);
    nchk++;
    if ({alu_opcode, alu_op1, alu_op2, busy, req_ready, rsp_valid} !== {opc[w], opa[w], opb[w], 1'b1, 4'd0, 4'd0}) begin
      nerr++;
      $display("FAIL exec: op=%0d a=%0d b=%0d busy=%b rdy=%b rv=%b want op=%0d a=%0d b=%0d busy=1 rdy=0 rv=0",
               alu_opcode, alu_op1, alu_op2, busy, req_ready, rsp_valid, opc[w], opa[w], opb[w]);
    end
    @(posedge clk); #1;
    @(negedge clk);
    nchk++;
    if (rsp_valid !== 4'd0) begin nerr++; $display("FAIL capt_valid: rsp_valid=%b want 0000", rsp_valid); end
    @(posedge clk); #1;
    rsp_ready = (bp == 0) ? 4'hF : ~oh;
    @(negedge clk);
    res = rsp_result; c = rsp_carry; z = rsp_zero;
    nchk++;
    if (rsp_valid !== oh) begin nerr++; $display("FAIL resp_valid: rsp_valid=%b want %b", rsp_valid, oh); end
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      if (i == bp - 1) rsp_ready = 4'hF;
      @(negedge clk);
      nchk++;
      if ({rsp_valid, rsp_result, rsp_carry, rsp_zero, req_ready, busy} !== {oh, res, c, z, 4'd0, 1'b1}) begin
        nerr++;
        $display("FAIL hold: rv=%b res=%0d c=%b z=%b rdy=%b busy=%b want rv=%b res=%0d c=%b z=%b rdy=0000 busy=1",
                 rsp_valid, rsp_result, rsp_carry, rsp_zero, req_ready, busy, oh, res, c, z);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 4'd0;
    req_valid = 4'd0;
    nchk++;
    if ({rsp_valid, busy} !== 5'd0) begin nerr++; $display("FAIL release: rv=%b busy=%b want 0000/0", rsp_valid, busy); end
  endtask

  task automatic test_reset();
    req_valid = 4'b0001;
    #2;
    nchk++;
    if ({req_ready, rsp_valid, busy, alu_opcode, alu_op1, alu_op2, rsp_result, rsp_carry, rsp_zero} !== 27'd0) begin
      nerr++;
      $display("FAIL reset: rdy=%b rv=%b busy=%b op=%0d a=%0d b=%0d res=%0d c=%b z=%b want all 0",
               req_ready, rsp_valid, busy, alu_opcode, alu_op1, alu_op2, rsp_result, rsp_carry, rsp_zero);
    end
    req_valid = 4'd0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    lg = 3;
  endtask

  task automatic test_single();
    int w; logic [3:0] r; logic c, z;
    set_op(0, 3'd0, 4'd10, 4'd10);
    do_op(4'b0001, 1'b0, 0, w, r, c, z);
    nchk++;
    if ({r, c, z} !== {4'd4, 1'b1, 1'b0}) begin nerr++; $display("FAIL single_add: res=%0d c=%b z=%b want 4/1/0", r, c, z); end
  endtask

  task automatic test_zero_borrow();
    int w; logic [3:0] r; logic c, z;
    set_op(2, 3'd1, 4'd5, 4'd5);
    do_op(4'b0100, 1'b0, 0, w, r, c, z);
    nchk++;
    if ({r, c, z} !== {4'd0, 1'b0, 1'b1}) begin nerr++; $display("FAIL sub_zero: res=%0d c=%b z=%b want 0/0/1", r, c, z); end
    set_op(2, 3'd1, 4'd3, 4'd5);
    do_op(4'b0100, 1'b0, 0, w, r, c, z);
    nchk++;
    if ({r, c, z} !== {4'd14, 1'b1, 1'b0}) begin nerr++; $display("FAIL sub_borrow: res=%0d c=%b z=%b want 14/1/0", r, c, z); end
  endtask

  task automatic test_contention();
    int w; logic [3:0] r; logic c, z;
    logic [5:0] exp_rsp [4];
    exp_rsp[0] = {1'b1, 1'b1, 4'd0};
    exp_rsp[1] = {1'b0, 1'b0, 4'd8};
    exp_rsp[2] = {1'b0, 1'b0, 4'd14};
    exp_rsp[3] = {1'b0, 1'b0, 4'd6};
    set_op(3, 3'd7, 4'd0, 4'd0);
    do_op(4'b1000, 1'b0, 0, w, r, c, z);
    set_op(0, 3'd2, 4'd15, 4'd0);
    set_op(1, 3'd4, 4'd12, 4'd10);
    set_op(2, 3'd5, 4'd12, 4'd10);
    set_op(3, 3'd6, 4'd12, 4'd10);
    for (int n = 0; n < 4; n++) begin
      do_op(4'b1111, 1'b1, 0, w, r, c, z);
      nchk++;
      if ({c, z, r} !== exp_rsp[n]) begin
        nerr++; $display("FAIL contention_%0d: c/z/res=%b want %b", n, {c, z, r}, exp_rsp[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w; logic [3:0] r; logic c, z;
    set_op(1, 3'd1, 4'd9, 4'd2);
    set_op(3, 3'd0, 4'd1, 4'd2);
    do_op(4'b1010, 1'b1, 5, w, r, c, z);
    nchk++;
    if ({r, c, z} !== {4'd7, 1'b0, 1'b0}) begin nerr++; $display("FAIL backpressure: res=%0d c=%b z=%b want 7/0/0", r, c, z); end
    do_op(4'b1000, 1'b0, 0, w, r, c, z);
    nchk++;
    if ({r, c, z} !== {4'd3, 1'b0, 1'b0}) begin nerr++; $display("FAIL next_accept: res=%0d c=%b z=%b want 3/0/0", r, c, z); end
  endtask

  task automatic test_wrap();
    int w; logic [3:0] r; logic c, z;
    set_op(0, 3'd6, 4'd5, 4'd3);
    do_op(4'b1001, 1'b0, 1, w, r, c, z);
    nchk++;
    if ({r, c, z} !== {4'd6, 1'b0, 1'b0}) begin nerr++; $display("FAIL wrap: res=%0d c=%b z=%b want 6/0/0", r, c, z); end
  endtask

  task automatic test_reset_midop();
    int w; logic [3:0] r; logic c, z;
    set_op(2, 3'd0, 4'd7, 4'd7);
    req_valid = 4'b0100;
    @(posedge clk); #1;
    req_valid = 4'b0110;
    #2 rstn = 1'b0;
    #1;
    nchk++;
    if ({req_ready, rsp_valid, busy, alu_opcode, alu_op1, alu_op2, rsp_result, rsp_carry, rsp_zero} !== 27'd0) begin
      nerr++;
      $display("FAIL midop_reset: rdy=%b rv=%b busy=%b op=%0d a=%0d b=%0d res=%0d want all 0",
               req_ready, rsp_valid, busy, alu_opcode, alu_op1, alu_op2, rsp_result);
    end
    req_valid = 4'd0;
    rsp_ready = 4'hF;
    @(posedge clk); #1 rstn = 1'b1;
    lg = 3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      nchk++;
      if ({rsp_valid, busy} !== 5'd0) begin nerr++; $display("FAIL no_stale_rsp: rv=%b busy=%b want 0000/0", rsp_valid, busy); end
    end
    @(posedge clk); #1;
    rsp_ready = 4'd0;
    set_op(0, 3'd4, 4'd15, 4'd9);
    set_op(1, 3'd0, 4'd1, 4'd1);
    do_op(4'b0011, 1'b0, 0, w, r, c, z);
    nchk++;
    if ({r, c, z} !== {4'd9, 1'b0, 1'b0}) begin nerr++; $display("FAIL post_reset: res=%0d c=%b z=%b want 9/0/0", r, c, z); end
  endtask

  task automatic test_random();
    int w; logic [3:0] r; logic c, z;
    logic [5:0] e;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) set_op(i, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
      do_op(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 3), w, r, c, z);
      e = alu_fn(opc[w], opa[w], opb[w]);
      nchk++;
      if ({c, z, r} !== e) begin nerr++; $display("FAIL random_%0d: req=%0d c/z/res=%b want %b", n, w, {c, z, r}, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_borrow();
    test_contention();
    test_back_to_back();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
